rotor_rev_pipe: RTL and testbench
=================================

ROTOR_REV_PIPE -- requirements
Module: rotor_rev_pipe

Interface
REQ-001 SHALL have parameter N, default 26: alphabet size, 2..2**W.
REQ-002 SHALL have parameter W, default 5: symbol width.
REQ-003 SHALL have parameter NOTCH, default 16: position whose exit raises notch_hit.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_clr  in  1  clears the written-bitmap, tbl_ok and cfg_err.
REQ-007 SHALL have port cfg_we  in  1  wiring write strobe.
REQ-008 SHALL have port cfg_addr  in  W  forward wiring input symbol.
REQ-009 SHALL have port cfg_data  in  W  forward wiring output symbol.
REQ-010 SHALL have port pos_load  in  1  load pos_in and ring_in.
REQ-011 SHALL have port pos_in  in  W  rotor position.
REQ-012 SHALL have port ring_in  in  W  ring setting.
REQ-013 SHALL have port step_en  in  1  advance position by one.
REQ-014 SHALL have port in_valid  in  1  input symbol valid.
REQ-015 SHALL have port in_ready  out  1  input accepted this cycle when high with in_valid.
REQ-016 SHALL have port data_in  in  W  input symbol.
REQ-017 SHALL have port out_valid  out  1  data_out valid.
REQ-018 SHALL have port out_ready  in  1  downstream accepts data_out.
REQ-019 SHALL have port data_out  out  W  reverse-translated symbol.
REQ-020 SHALL have port pos_out  out  W  current position register.
REQ-021 SHALL have port notch_hit  out  1  one-cycle carry pulse to next rotor.
REQ-022 SHALL have port tbl_ok  out  1  inverse table complete and consistent.
REQ-023 SHALL have port cfg_err  out  1  sticky configuration error.

Function
REQ-024 SHALL, on cfg_we with cfg_addr<N and cfg_data<N, store inv[cfg_data]=cfg_addr and set bitmap[cfg_data].
REQ-025 SHALL set cfg_err when cfg_addr>=N, cfg_data>=N, or bitmap[cfg_data] already set; the write is ignored.
REQ-026 SHALL drive tbl_ok high the cycle after all N bitmap bits are set with cfg_err low; cfg_clr has priority over cfg_we in the same cycle.
REQ-027 SHALL hold in_ready = tbl_ok AND (NOT out_valid OR out_ready) AND NOT cfg_we.
REQ-028 SHALL compute off = (pos - ring) mod N and register data_out = (inv[(data_in + off) mod N] - off) mod N one cycle after transfer; all sums are formed in W+1 bits, then wrapped by a single conditional subtract/add of N.
REQ-029 SHALL set out_valid on transfer and clear it on out_ready without a new transfer; with both in the same cycle, out_valid stays high and data_out updates (full throughput).
REQ-030 SHALL hold data_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-031 SHALL translate using the position value before any same-cycle step or load.
REQ-032 SHALL give pos_load priority over step_en; pos_in or ring_in >=N loads 0 and sets cfg_err.
REQ-033 SHALL, on step_en, set pos = pos+1, wrapping N-1 to 0.
REQ-034 SHALL pulse notch_hit for exactly one cycle, the cycle after a step from pos==NOTCH; a load never raises notch_hit.
REQ-035 SHALL treat data_in>=N on a transfer as symbol 0 and set cfg_err.

Reset
REQ-036 SHALL, while rst_n=0, force pos=0, ring=0, bitmap=0, tbl_ok=0, cfg_err=0, out_valid=0, data_out=0, notch_hit=0; inv contents are not reset.
REQ-037 SHALL discard any in-flight output on reset; after release, in_ready stays 0 until the table is rewritten.

Verification
REQ-038 SHALL cover: identity wiring (inv[i]=i) written, pos=7 ring=0, data_in=12 -> data_out=12 one cycle later, out_valid=1.
REQ-039 SHALL cover: forward wiring i->(i+1) mod 26, pos=3, ring=0, data_in=0 -> data_out=25; data_in=5 -> 4.
REQ-040 SHALL cover: pos_load 16, step_en one cycle -> pos_out=17, notch_hit=1 for exactly one cycle; pos 25 plus step -> 0, notch_hit=0.
REQ-041 SHALL cover: out_ready=0 with two back-to-back inputs -> first result held, in_ready=0, second accepted the cycle out_ready rises, no symbol lost or duplicated.
REQ-042 SHALL cover: writes (0->5) then (1->5) -> cfg_err=1, tbl_ok=0; cfg_clr -> cfg_err=0.
REQ-043 SHALL cover: rst_n low mid-stream with out_valid=1 -> out_valid=0, pos_out=0, tbl_ok=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rotor_rev_pipe.sv
// rotor_rev_pipe -- reverse-path stage of a single cipher rotor.
//
// The forward wiring is loaded one pair at a time through the cfg_* port and
// stored as its inverse, so the reverse lookup is a single table read.  Each
// accepted input symbol is shifted by the rotor offset (position minus ring
// setting), passed through the inverse wiring, shifted back and registered.
// Output uses a valid/ready handshake with full throughput.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cfg_clr                clears the written-bitmap, tbl_ok and cfg_err
//   cfg_we/addr/data       forward wiring write: cfg_addr maps to cfg_data
//   pos_load/pos_in/ring_in load rotor position and ring setting
//   step_en                advance the position by one (mod N)
//   in_valid/in_ready/data_in    input symbol handshake
//   out_valid/out_ready/data_out output symbol handshake
//   pos_out                current position
//   notch_hit              one-cycle carry pulse after stepping out of NOTCH
//   tbl_ok                 inverse table complete and consistent
//   cfg_err                sticky configuration / input error
module rotor_rev_pipe #(
  parameter int N     = 26,
  parameter int W     = 5,
  parameter int NOTCH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_clr,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         pos_load,
  input  logic [W-1:0] pos_in,
  input  logic [W-1:0] ring_in,
  input  logic         step_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [W-1:0] pos_out,
  output logic         notch_hit,
  output logic         tbl_ok,
  output logic         cfg_err
);

  localparam logic [W:0]   N_X     = (W+1)'(N);
  localparam logic [W-1:0] N_LO    = N_X[W-1:0];
  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [W-1:0] NOTCH_W = W'(NOTCH);

  // Inverse wiring table; deliberately not reset.
  logic [W-1:0] inv_mem [0:N-1];

  logic [W-1:0] pos_q, pos_d, ring_q, ring_d;
  logic [N-1:0] bitmap_q, bitmap_d, data_onehot;
  logic         tbl_ok_q, tbl_ok_d, cfg_err_q, cfg_err_d;
  logic         out_valid_q, out_valid_d, notch_hit_q, notch_hit_d;
  logic [W-1:0] data_out_q, data_out_d;

  logic         addr_bad, data_bad, dup, wr_ok, wr_err;
  logic         pos_bad, ring_bad, din_bad, xfer;
  logic [W:0]   off_raw, sum_raw, res_raw;
  logic [W-1:0] off, din_s, idx, inv_val, res;

  // One-hot decode of the written output symbol, and per-bit bitmap update.
  for (genvar gi = 0; gi < N; gi++) begin : g_bitmap
    assign data_onehot[gi] = (cfg_data == W'(gi));
    assign bitmap_d[gi]    = cfg_clr ? 1'b0 : (bitmap_q[gi] | (wr_ok & data_onehot[gi]));
  end

  assign in_ready = tbl_ok_q & (~out_valid_q | out_ready) & ~cfg_we;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    addr_bad = ({1'b0, cfg_addr} >= N_X);
    data_bad = ({1'b0, cfg_data} >= N_X);
    dup      = |(bitmap_q & data_onehot);
    wr_ok    = cfg_we & ~cfg_clr & ~addr_bad & ~data_bad & ~dup;
    wr_err   = cfg_we & ~cfg_clr & ~wr_ok;

    // Offset = (pos - ring) mod N.  Both operands are < N, so the MSB of the
    // W+1-bit difference is a borrow flag; adding N modulo 2**W fixes it.
    off_raw = {1'b0, pos_q} - {1'b0, ring_q};
    off     = off_raw[W] ? (off_raw[W-1:0] + N_LO) : off_raw[W-1:0];

    din_bad = ({1'b0, data_in} >= N_X);
    din_s   = din_bad ? '0 : data_in;
    sum_raw = {1'b0, din_s} + {1'b0, off};
    idx     = (sum_raw >= N_X) ? (sum_raw[W-1:0] - N_LO) : sum_raw[W-1:0];
    inv_val = inv_mem[idx];
    res_raw = {1'b0, inv_val} - {1'b0, off};
    res     = res_raw[W] ? (res_raw[W-1:0] + N_LO) : res_raw[W-1:0];

    // Position: load beats step; out-of-range load values become 0.
    pos_bad  = ({1'b0, pos_in} >= N_X);
    ring_bad = ({1'b0, ring_in} >= N_X);
    pos_d    = pos_q;
    ring_d   = ring_q;
    if (pos_load) begin
      pos_d  = pos_bad ? '0 : pos_in;
      ring_d = ring_bad ? '0 : ring_in;
    end else if (step_en) begin
      pos_d  = (pos_q == LAST) ? '0 : (pos_q + W'(1));
    end
    notch_hit_d = step_en & ~pos_load & (pos_q == NOTCH_W);

    cfg_err_d = cfg_clr ? 1'b0
              : (cfg_err_q | wr_err | (pos_load & (pos_bad | ring_bad)) | (xfer & din_bad));
    tbl_ok_d  = cfg_clr ? 1'b0 : ((&bitmap_q) & ~cfg_err_q);

    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      data_out_d  = res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) inv_mem[cfg_data] <= cfg_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      ring_q      <= '0;
      bitmap_q    <= '0;
      tbl_ok_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      notch_hit_q <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      ring_q      <= ring_d;
      bitmap_q    <= bitmap_d;
      tbl_ok_q    <= tbl_ok_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      notch_hit_q <= notch_hit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign pos_out   = pos_q;
  assign notch_hit = notch_hit_q;
  assign tbl_ok    = tbl_ok_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_rotor_rev_pipe.sv
// Self-checking bench for rotor_rev_pipe: table-driven translation vectors,
// hand-written corner sequences and a randomized run against a reference
// model that inverts the forward wiring by search.
module tb_rotor_rev_pipe;
  localparam int N = 26;
  localparam int W = 5;
  localparam int NOTCH = 16;

  logic clk, rst_n;
  logic cfg_clr, cfg_we, pos_load, step_en, in_valid, out_ready;
  logic [W-1:0] cfg_addr, cfg_data, pos_in, ring_in, data_in;
  logic in_ready, out_valid, notch_hit, tbl_ok, cfg_err;
  logic [W-1:0] data_out, pos_out;

  rotor_rev_pipe #(.N(N), .W(W), .NOTCH(NOTCH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_clr(cfg_clr), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pos_load(pos_load),
    .pos_in(pos_in), .ring_in(ring_in), .step_en(step_en),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .pos_out(pos_out), .notch_hit(notch_hit), .tbl_ok(tbl_ok), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cur_kind = -1;

  typedef struct {
    int kind; int pos; int ring; int din; int exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward wiring families: identity, shift by one, affine 3*i+1.
  function automatic int fwd(input int kind, input int i);
    if (kind == 0) return i;
    if (kind == 1) return (i + 1) % N;
    return (3 * i + 1) % N;
  endfunction

  // Reference: shift in by offset, find the forward preimage, shift back.
  function automatic int ref_rev(input int kind, input int din, input int p, input int r);
    int off, d, t, pre;
    off = ((p - r) % N + N) % N;
    d   = (din < N) ? din : 0;
    t   = (d + off) % N;
    pre = 0;
    for (int i = 0; i < N; i++) if (fwd(kind, i) == t) pre = i;
    return ((pre - off) % N + N) % N;
  endfunction

  task automatic load_table(input int kind);
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_we = 1'b1; cfg_addr = W'(i); cfg_data = W'(fwd(kind, i));
      tick();
    end
    cfg_we = 1'b0;
    tick();
    check("tbl_ok_after_load", int'(tbl_ok), 1);
    check("cfg_err_after_load", int'(cfg_err), 0);
    cur_kind = kind;
  endtask

  task automatic load_pos(input int p, input int r);
    pos_load = 1'b1; pos_in = W'(p); ring_in = W'(r);
    tick();
    pos_load = 1'b0;
  endtask

  int exp_a, exp_b, mpos, mring, md;
  bit mv, mnotch, xfer, exp_rdy;

  initial begin
    vecs[0] = '{0, 7, 0, 12, 12};
    vecs[1] = '{0, 20, 9, 3, 3};
    vecs[2] = '{1, 3, 0, 0, 25};
    vecs[3] = '{1, 3, 0, 5, 4};
    vecs[4] = '{1, 15, 22, 10, 9};
    vecs[5] = '{2, 10, 4, 2, 5};
    vecs[6] = '{2, 2, 5, 20, 17};

    rst_n = 1'b0; cfg_clr = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    pos_load = 0; pos_in = 0; ring_in = 0; step_en = 0;
    in_valid = 0; data_in = 0; out_ready = 1;
    tick(); tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_pos_out", int'(pos_out), 0);
    check("rst_notch", int'(notch_hit), 0);
    check("rst_tbl_ok", int'(tbl_ok), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    tick();

    // Table-driven translation vectors.
    foreach (vecs[k]) begin
      if (vecs[k].kind != cur_kind) load_table(vecs[k].kind);
      load_pos(vecs[k].pos, vecs[k].ring);
      in_valid = 1'b1; data_in = W'(vecs[k].din); out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", k), int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", k), int'(out_valid), 1);
      check($sformatf("vec%0d_data_out", k), int'(data_out), vecs[k].exp);
      tick();
      check($sformatf("vec%0d_drained", k), int'(out_valid), 0);
    end

    // Notch: step out of NOTCH pulses once; load never pulses; wrap from N-1.
    load_pos(16, 0);
    check("notch_load_pos", int'(pos_out), 16);
    check("notch_load_no_pulse", int'(notch_hit), 0);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    check("notch_step_pos", int'(pos_out), 17);
    check("notch_pulse", int'(notch_hit), 1);
    tick();
    check("notch_pulse_end", int'(notch_hit), 0);
    check("notch_pos_hold", int'(pos_out), 17);
    load_pos(25, 0);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    check("wrap_pos", int'(pos_out), 0);
    check("wrap_no_notch", int'(notch_hit), 0);

    // Backpressure: two back-to-back inputs with out_ready low.
    load_pos(9, 2);
    exp_a = ref_rev(cur_kind, 4, 9, 2);
    exp_b = ref_rev(cur_kind, 19, 9, 2);
    out_ready = 1'b0; in_valid = 1'b1; data_in = 5'd4;
    #1;
    check("bp_first_ready", int'(in_ready), 1);
    tick();
    data_in = 5'd19;
    #1;
    check("bp_second_blocked", int'(in_ready), 0);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_data", int'(data_out), exp_a);
    tick();
    check("bp_hold_data2", int'(data_out), exp_a);
    check("bp_still_blocked", int'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_rises", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", int'(out_valid), 1);
    check("bp_second_data", int'(data_out), exp_b);
    tick();
    check("bp_drained", int'(out_valid), 0);

    // Randomized run against the reference model.
    load_pos(0, 0);
    mpos = 0; mring = 0; mv = 0; md = 0; mnotch = 0;
    for (int c = 0; c < 300; c++) begin
      pos_load  = ($urandom_range(0, 9) == 0);
      pos_in    = W'($urandom_range(0, N - 1));
      ring_in   = W'($urandom_range(0, N - 1));
      step_en   = ($urandom_range(0, 2) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      data_in   = W'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !mv || out_ready;
      check("rnd_in_ready", int'(in_ready), int'(exp_rdy));
      xfer = in_valid && exp_rdy;
      if (xfer) md = ref_rev(cur_kind, int'(data_in), mpos, mring);
      mv = xfer ? 1'b1 : (out_ready ? 1'b0 : mv);
      mnotch = step_en && !pos_load && (mpos == NOTCH);
      if (pos_load) begin
        mpos = int'(pos_in); mring = int'(ring_in);
      end else if (step_en) begin
        mpos = (mpos + 1) % N;
      end
      tick();
      check("rnd_out_valid", int'(out_valid), int'(mv));
      if (mv) check("rnd_data_out", int'(data_out), md);
      check("rnd_pos_out", int'(pos_out), mpos);
      check("rnd_notch", int'(notch_hit), int'(mnotch));
    end
    pos_load = 0; step_en = 0; in_valid = 0; out_ready = 1;
    tick();

    // Configuration errors: duplicate output symbol, out-of-range address.
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'd5; tick();
    cfg_addr = 5'd1; cfg_data = 5'd5; tick();
    cfg_we = 1'b0;
    check("dup_cfg_err", int'(cfg_err), 1);
    tick();
    check("dup_tbl_ok", int'(tbl_ok), 0);
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    check("clr_cfg_err", int'(cfg_err), 0);
    cfg_we = 1'b1; cfg_addr = 5'd30; cfg_data = 5'd2; tick();
    cfg_we = 1'b0;
    check("addr_range_err", int'(cfg_err), 1);

    // Out-of-range data_in is treated as symbol 0 and flags an error.
    load_table(0);
    load_pos(3, 0);
    in_valid = 1'b1; data_in = 5'd30;
    tick();
    in_valid = 1'b0;
    check("bad_din_valid", int'(out_valid), 1);
    check("bad_din_data", int'(data_out), 0);
    check("bad_din_err", int'(cfg_err), 1);
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    load_pos(27, 4);
    check("bad_pos_zero", int'(pos_out), 0);
    check("bad_pos_err", int'(cfg_err), 1);

    // Asynchronous reset mid-stream with an output held.
    load_table(1);
    load_pos(5, 0);
    out_ready = 1'b0; in_valid = 1'b1; data_in = 5'd7;
    tick();
    in_valid = 1'b0;
    check("mid_valid_before", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_pos_out", int'(pos_out), 0);
    check("async_tbl_ok", int'(tbl_ok), 0);
    check("async_data_out", int'(data_out), 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    check("post_rst_no_output", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
